// File: rtl/board_input_cond.sv
// Board input conditioning: synchronizers, button/switch debounce, press pulse and SoC reset
// sequencing. Define BIC_SW_DEBOUNCE_EN to debounce every switch bit like the button.
module board_input_cond #(
  parameter int SW_WIDTH    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 80000,
  parameter int DB_SAMPLES  = 4,
  parameter int RST_HOLD    = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  input  logic                rx_i,
  output logic                btn_o,
  output logic                btn_press_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                rx_o,
  output logic                srst_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
  localparam int HW = $clog2(RST_HOLD + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  logic [SYNC_STAGES-1:0]               btn_sync;
  logic [SYNC_STAGES-1:0]               rx_sync;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;
  logic                                 btn_s;
  logic [SW_WIDTH-1:0]                  sw_s;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_sync <= '0;
      rx_sync  <= '1;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_i};
      rx_sync  <= {rx_sync[SYNC_STAGES-2:0], rx_i};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];
  assign rx_o  = rx_sync[SYNC_STAGES-1];

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == TICK_LAST);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  logic          btn_db;
  logic [CW-1:0] btn_cnt;
  logic          btn_prev;
  logic          press;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_db  <= 1'b0;
      btn_cnt <= '0;
    end else if (tick) begin
      if (btn_s == btn_db) begin
        btn_cnt <= '0;
      end else if (btn_cnt == DB_LAST) begin
        btn_db  <= btn_s;
        btn_cnt <= '0;
      end else begin
        btn_cnt <= btn_cnt + CW'(1);
      end
    end
  end

  // Pulse lands the cycle after btn_db rises; releases and held levels give nothing.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_prev <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      press    <= btn_db & ~btn_prev;
    end
  end

  assign btn_o       = btn_db;
  assign btn_press_o = press;

`ifdef BIC_SW_DEBOUNCE_EN
  logic [SW_WIDTH-1:0] sw_db;
  logic [CW-1:0]       sw_cnt [SW_WIDTH];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sw_db <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        sw_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sw_s[i] == sw_db[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_cnt[i] == DB_LAST) begin
          sw_db[i]  <= sw_s[i];
          sw_cnt[i] <= '0;
        end else begin
          sw_cnt[i] <= sw_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign sw_o = sw_db;
`else
  assign sw_o = sw_s;
`endif

  // Hold counter stops once srst drops, so it saturates at RST_HOLD.
  logic [HW-1:0] hold_cnt;
  logic          srst;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      hold_cnt <= '0;
      srst     <= 1'b1;
    end else if (srst) begin
      hold_cnt <= hold_cnt + HW'(1);
      if (hold_cnt == HOLD_LAST) begin
        srst <= 1'b0;
      end
    end
  end

  assign srst_o = srst;

endmodule

// File: tb/tb_board_input_cond.sv
// Self-checking bench for board_input_cond: directed scenarios followed by random stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_board_input_cond;

  localparam int SW = 16;
  localparam int SS = 2;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RH = 8;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          btn = 1'b0;
  logic          rx = 1'b1;
  logic [SW-1:0] sw = '0;
  logic          btn_o, btn_press_o, rx_o, srst_o;
  logic [SW-1:0] sw_o;

  int checks = 0;
  int errors = 0;

  board_input_cond #(
    .SW_WIDTH    (SW),
    .SYNC_STAGES (SS),
    .TICK_DIV    (TD),
    .DB_SAMPLES  (DB),
    .RST_HOLD    (RH)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .btn_i       (btn),
    .sw_i        (sw),
    .rx_i        (rx),
    .btn_o       (btn_o),
    .btn_press_o (btn_press_o),
    .sw_o        (sw_o),
    .rx_o        (rx_o),
    .srst_o      (srst_o)
  );

  always #5 clk = ~clk;

  // Model: edges since reset release, delay-line queues, runs of differing ticks.
  int            cyc;
  logic          q_btn[$];
  logic          q_rx[$];
  logic [SW-1:0] q_sw[$];
  logic          m_btn_s, m_rx_s;
  logic [SW-1:0] m_sw_s;
  logic          m_btn, m_btn_last, m_press;
  int            m_run;
  logic [SW-1:0] m_sw;
  int            m_sw_run[SW];

  int at, pat, presses, hi, changed;

  task automatic model_reset();
    cyc = 0;
    q_btn = {};
    q_rx = {};
    q_sw = {};
    for (int i = 0; i < SS - 1; i++) begin
      q_btn.push_back(1'b0);
      q_rx.push_back(1'b1);
      q_sw.push_back('0);
    end
    m_btn_s = 1'b0;
    m_rx_s = 1'b1;
    m_sw_s = '0;
    m_btn = 1'b0;
    m_btn_last = 1'b0;
    m_press = 1'b0;
    m_run = 0;
    m_sw = '0;
    for (int i = 0; i < SW; i++) m_sw_run[i] = 0;
  endtask

  task automatic model_edge(input logic b, input logic r, input logic [SW-1:0] s);
    bit tk;
    cyc++;
    tk = (cyc % TD) == 0;
    m_press = m_btn && !m_btn_last;
    m_btn_last = m_btn;
    if (tk) begin
      if (m_btn_s != m_btn) begin
        m_run++;
        if (m_run == DB) begin
          m_btn = m_btn_s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
`ifdef BIC_SW_DEBOUNCE_EN
      for (int i = 0; i < SW; i++) begin
        if (m_sw_s[i] != m_sw[i]) begin
          m_sw_run[i]++;
          if (m_sw_run[i] == DB) begin
            m_sw[i] = m_sw_s[i];
            m_sw_run[i] = 0;
          end
        end else begin
          m_sw_run[i] = 0;
        end
      end
`endif
    end
    q_btn.push_back(b);
    q_rx.push_back(r);
    q_sw.push_back(s);
    m_btn_s = q_btn.pop_front();
    m_rx_s = q_rx.pop_front();
    m_sw_s = q_sw.pop_front();
`ifndef BIC_SW_DEBOUNCE_EN
    m_sw = m_sw_s;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".btn_o"}, 32'(btn_o), 32'(m_btn));
    chk({tag, ".btn_press_o"}, 32'(btn_press_o), 32'(m_press));
    chk({tag, ".sw_o"}, 32'(sw_o), 32'(m_sw));
    chk({tag, ".rx_o"}, 32'(rx_o), 32'(m_rx_s));
    chk({tag, ".srst_o"}, 32'(srst_o), 32'(cyc < RH));
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (arst_n) model_edge(btn, rx, sw);
    #1 check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();

    // Reset hold and release sequencing
    repeat (5) step("rst_hold");
    arst_n = 1'b1;
    at = 0;
    for (int k = 1; k <= 12; k++) begin
      step("rst_seq");
      if (at == 0 && srst_o === 1'b0) at = k;
    end
    chk("srst_fall_edge", 32'(at), 32'd8);

    // Clean press
    btn = 1'b1;
    at = 0;
    pat = 0;
    presses = 0;
    for (int k = 1; k <= 40; k++) begin
      step("press");
      if (at == 0 && btn_o === 1'b1) at = k;
      if (btn_press_o === 1'b1) begin
        presses++;
        if (pat == 0) pat = k;
      end
    end
    chk("press_latency", 32'(at > 0 && at <= 14), 32'd1);
    chk("press_pulse_cycle", 32'(pat), 32'(at + 1));
    repeat (100) begin
      step("press_hold");
      if (btn_press_o === 1'b1) presses++;
    end
    chk("press_count", 32'(presses), 32'd1);

    // Release
    btn = 1'b0;
    at = 0;
    presses = 0;
    for (int k = 1; k <= 30; k++) begin
      step("release");
      if (at == 0 && btn_o === 1'b0) at = k;
      if (btn_press_o === 1'b1) presses++;
    end
    chk("release_latency", 32'(at > 0 && at <= 14), 32'd1);
    chk("release_no_pulse", 32'(presses), 32'd0);

    // Bounce shorter than the acceptance window
    hi = 0;
    presses = 0;
    for (int k = 0; k < 60; k++) begin
      if (k < 40 && k % 5 == 0) btn = ~btn;
      if (k >= 40) btn = 1'b0;
      step("bounce");
      if (btn_o === 1'b1) hi++;
      if (btn_press_o === 1'b1) presses++;
    end
    chk("bounce_btn_high", 32'(hi), 32'd0);
    chk("bounce_no_pulse", 32'(presses), 32'd0);

    // Switches
    sw = 16'hA5C3;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      step("sw");
      if (at == 0 && sw_o === 16'hA5C3) at = k;
    end
`ifdef BIC_SW_DEBOUNCE_EN
    chk("sw_latency", 32'(at > 0 && at <= 14), 32'd1);
`else
    chk("sw_latency", 32'(at), 32'd2);
`endif
    sw[0] = ~sw[0];
    step("sw_glitch");
    sw[0] = ~sw[0];
    changed = 0;
    for (int k = 0; k < 20; k++) begin
      step("sw_glitch");
      if (sw_o !== 16'hA5C3) changed++;
    end
`ifdef BIC_SW_DEBOUNCE_EN
    chk("sw_glitch_filtered", 32'(changed), 32'd0);
`else
    chk("sw_glitch_passed", 32'(changed), 32'd1);
`endif

    // RX two-cycle latency
    rx = 1'b0;
    step("rx");
    chk("rx_lat1", 32'(rx_o), 32'd1);
    step("rx");
    chk("rx_lat2", 32'(rx_o), 32'd0);
    rx = 1'b1;
    step("rx");
    step("rx");
    chk("rx_back", 32'(rx_o), 32'd1);

    // Mid-operation reset during a partially counted change
    btn = 1'b1;
    repeat (30) step("pre_mid");
    chk("mid_btn_high", 32'(btn_o), 32'd1);
    btn = 1'b0;
    repeat (6) step("mid_partial");
    chk("mid_partial_hold", 32'(btn_o), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_btn", 32'(btn_o), 32'd0);
    chk("mid_rst_srst", 32'(srst_o), 32'd1);
    chk("mid_rst_rx", 32'(rx_o), 32'd1);
    model_reset();
    btn = 1'b1;
    repeat (2) step("mid_rst_hold");
    arst_n = 1'b1;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      step("post_rst");
      if (at == 0 && btn_o === 1'b1) at = k;
    end
    chk("post_rst_full_accept", 32'(at), 32'd12);

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(11) == 0) btn = ~btn;
      if ($urandom_range(29) == 0) sw = 16'($urandom);
      if ($urandom_range(39) == 0) sw[$urandom_range(SW - 1)] ^= 1'b1;
      if ($urandom_range(2) == 0) rx = 1'($urandom_range(1));
      if (i == 350) begin
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        step("rnd_rst");
        arst_n = 1'b1;
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
